clock_set_ctrl: RTL and testbench

- Controller that sequences the seconds/minutes/hours timekeeping counter.
- Generates the 1-per-second advance enable (`tick`) while running.
- Runs a button-driven time-set FSM that snapshots the current time, lets the user edit hours then minutes, and commits the edit as a one-cycle parallel load.
- Sits between the debounced front-panel buttons and the timekeeping counter; the counter advances only when `tick`=1 and loads when `load`=1.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/clock_set_ctrl.sv | 167 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared state encoding and field limits for the clock-set path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 4;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 4'd11;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..TICK_DIV-1 counter with a wrap indication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    output logic [$clog2(TICK_DIV)-1:0] count,
    output logic                        wrap
);

    localparam int               CNT_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count == C_LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A clear overrides the wrap so no tick escapes on the commit edge.
    assign wrap = (count == C_LAST) && !clr;

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
// Module      : clock_set_ctrl
// Description : Tick generation and button-driven time-set FSM for the clock.
//               Optional auto-repeat on held increment: CLOCK_SET_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int REPEAT_DLY = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [SEC_W-1:0] cur_seconds,
    input  logic [MIN_W-1:0] cur_minutes,
    input  logic [HR_W-1:0]  cur_hours,
    output logic             tick,
    output logic             load,
    output logic [SEC_W-1:0] load_seconds,
    output logic [MIN_W-1:0] load_minutes,
    output logic [HR_W-1:0]  load_hours,
    output logic [1:0]       mode,
    output logic             blink
);

    localparam int               CNT_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(TICK_DIV / 2);

    state_t            r_state;
    logic              r_mode_q;
    logic              r_inc_q;
    logic [HR_W-1:0]   r_hr_sh;
    logic [MIN_W-1:0]  r_min_sh;

    logic              w_press_mode;
    logic              w_press_inc;
    logic              w_inc_ev;
    logic              w_clr;
    logic              w_wrap;
    logic              w_blink_set;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_unused;

    assign w_press_mode = btn_mode & ~r_mode_q;
    assign w_press_inc  = btn_inc  & ~r_inc_q;
    assign w_clr        = (r_state == COMMIT);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .count (w_cnt),
        .wrap  (w_wrap)
    );

    // Blink is registered, so it is decided from the count the prescaler
    // will hold after this edge.
    assign w_cnt_nxt   = (w_clr || w_wrap) ? '0 : w_cnt + 1'b1;
    assign w_blink_set = (w_cnt_nxt < C_HALF);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int                HOLD_W      = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(REPEAT_DLY - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              w_in_set;
    logic              w_rpt;

    assign w_in_set = (r_state == SET_HR) || (r_state == SET_MIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (!w_in_set || !btn_inc || w_press_mode || w_press_inc ||
                     (r_hold == C_HOLD_LAST)) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign w_rpt    = w_in_set && btn_inc && !w_press_inc && (r_hold == C_HOLD_LAST);
    assign w_inc_ev = w_press_inc | w_rpt;
    assign w_unused = ^cur_seconds;
`else
    assign w_inc_ev = w_press_inc;
    assign w_unused = (^cur_seconds) ^ (REPEAT_DLY != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_mode_q     <= 1'b0;
            r_inc_q      <= 1'b0;
            r_hr_sh      <= '0;
            r_min_sh     <= '0;
            tick         <= 1'b0;
            load         <= 1'b0;
            load_seconds <= '0;
            load_minutes <= '0;
            load_hours   <= '0;
            blink        <= 1'b1;
        end else begin
            r_mode_q <= btn_mode;
            r_inc_q  <= btn_inc;
            tick     <= 1'b0;
            load     <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_press_mode) begin
                        r_hr_sh  <= cur_hours;
                        r_min_sh <= cur_minutes;
                        r_state  <= SET_HR;
                        blink    <= w_blink_set;
                    end else begin
                        tick  <= w_wrap;
                        blink <= 1'b1;
                    end
                end
                SET_HR: begin
                    blink <= w_blink_set;
                    if (w_press_mode) begin
                        r_state <= SET_MIN;
                    end else if (w_inc_ev) begin
                        r_hr_sh <= (r_hr_sh == HR_MAX) ? '0 : r_hr_sh + 1'b1;
                    end
                end
                SET_MIN: begin
                    if (w_press_mode) begin
                        r_state      <= COMMIT;
                        load         <= 1'b1;
                        load_hours   <= r_hr_sh;
                        load_minutes <= r_min_sh;
                        load_seconds <= '0;
                        blink        <= 1'b1;
                    end else begin
                        blink <= w_blink_set;
                        if (w_inc_ev) begin
                            r_min_sh <= (r_min_sh == MIN_MAX) ? '0 : r_min_sh + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_state <= RUN;
                    blink   <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                    blink   <= 1'b1;
                end
            endcase
        end
    end

    assign mode = r_state;

endmodule

`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
// ============================================================================
// Module      : tb_clock_set_ctrl
// Description : Directed self-checking bench for clock_set_ctrl (TICK_DIV=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] cur_seconds = '0;
    logic [5:0] cur_minutes = '0;
    logic [3:0] cur_hours = '0;
    logic       tick;
    logic       load;
    logic [5:0] load_seconds;
    logic [5:0] load_minutes;
    logic [3:0] load_hours;
    logic [1:0] mode;
    logic       blink;

    int n_vec = 0;
    int n_err = 0;

    clock_set_ctrl #(
        .TICK_DIV   (10),
        .REPEAT_DLY (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .cur_seconds  (cur_seconds),
        .cur_minutes  (cur_minutes),
        .cur_hours    (cur_hours),
        .tick         (tick),
        .load         (load),
        .load_seconds (load_seconds),
        .load_minutes (load_minutes),
        .load_hours   (load_hours),
        .mode         (mode),
        .blink        (blink)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode_btn();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc_btn();
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick); end
        n_vec++; if (load !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b expected 0", load); end
        n_vec++; if ({load_hours, load_minutes, load_seconds} !== 16'h0) begin
            n_err++; $display("FAIL reset_load_vals: got %0d:%0d:%0d expected 0:0:0", load_hours, load_minutes, load_seconds);
        end
        n_vec++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        n_vec++; if (blink !== 1'b1) begin n_err++; $display("FAIL reset_blink: got %b expected 1", blink); end
        rst = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            step();
            n_vec++; if (tick !== ((k % 10) == 0)) begin
                n_err++; $display("FAIL idle_tick cycle %0d: got %b expected %b", k, tick, ((k % 10) == 0));
            end
            n_vec++; if (load !== 1'b0 || mode !== 2'd0 || blink !== 1'b1) begin
                n_err++; $display("FAIL idle_state cycle %0d: got load=%b mode=%0d blink=%b expected 0 0 1", k, load, mode, blink);
            end
        end
    endtask

    task automatic test_rst_mid_edit();
        cur_hours = 4'd9; cur_minutes = 6'd10; cur_seconds = 6'd5;
        press_mode_btn();
        press_mode_btn();
        n_vec++; if (mode !== 2'd2) begin n_err++; $display("FAIL midrst_pre_mode: got %0d expected 2", mode); end
        press_inc_btn();
        rst = 1'b1;
        step();
        n_vec++; if (mode !== 2'd0) begin n_err++; $display("FAIL midrst_mode: got %0d expected 0", mode); end
        n_vec++; if (load !== 1'b0) begin n_err++; $display("FAIL midrst_load: got %b expected 0", load); end
        n_vec++; if ({load_hours, load_minutes} !== 10'h0) begin
            n_err++; $display("FAIL midrst_vals: got %0d:%0d expected 0:0", load_hours, load_minutes);
        end
        step();
        n_vec++; if (load !== 1'b0) begin n_err++; $display("FAIL midrst_load2: got %b expected 0", load); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_set();
        int ones;
        cur_hours = 4'd3; cur_minutes = 6'd15; cur_seconds = 6'd42;
        btn_mode = 1'b1;
        step();
        n_vec++; if (mode !== 2'd1) begin n_err++; $display("FAIL set_enter_hr: got %0d expected 1", mode); end
        btn_mode = 1'b0;
        step();
        ones = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL set_tick_suppressed: got %b expected 0", tick); end
            ones += int'(blink);
        end
        n_vec++; if (ones !== 5) begin n_err++; $display("FAIL set_blink_duty: got %0d high cycles expected 5", ones); end
        press_inc_btn();
        press_inc_btn();
        btn_mode = 1'b1;
        step();
        n_vec++; if (mode !== 2'd2) begin n_err++; $display("FAIL set_enter_min: got %0d expected 2", mode); end
        btn_mode = 1'b0;
        step();
        press_inc_btn();
        press_inc_btn();
        press_inc_btn();
        btn_mode = 1'b1;
        step();
        n_vec++; if (mode !== 2'd3 || load !== 1'b1) begin
            n_err++; $display("FAIL set_commit: got mode=%0d load=%b expected 3 1", mode, load);
        end
        n_vec++; if (load_hours !== 4'd5 || load_minutes !== 6'd18 || load_seconds !== 6'd0) begin
            n_err++; $display("FAIL set_load_vals: got %0d:%0d:%0d expected 5:18:0", load_hours, load_minutes, load_seconds);
        end
        n_vec++; if (blink !== 1'b1) begin n_err++; $display("FAIL set_commit_blink: got %b expected 1", blink); end
        btn_mode = 1'b0;
        step();
        n_vec++; if (mode !== 2'd0 || load !== 1'b0) begin
            n_err++; $display("FAIL set_back_run: got mode=%0d load=%b expected 0 0", mode, load);
        end
        n_vec++; if (load_hours !== 4'd5 || load_minutes !== 6'd18) begin
            n_err++; $display("FAIL set_load_hold: got %0d:%0d expected 5:18", load_hours, load_minutes);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++; if (tick !== (k == 10)) begin
                n_err++; $display("FAIL post_commit_tick cycle %0d: got %b expected %b", k, tick, (k == 10));
            end
        end
    endtask

    task automatic test_wrap();
        // Hour wrap 11 -> 0 must leave minutes untouched.
        cur_hours = 4'd11; cur_minutes = 6'd30; cur_seconds = 6'd7;
        press_mode_btn();
        press_inc_btn();
        press_mode_btn();
        press_inc_btn();
        btn_mode = 1'b1;
        step();
        n_vec++; if (load !== 1'b1 || load_hours !== 4'd0 || load_minutes !== 6'd31) begin
            n_err++; $display("FAIL hour_wrap: got load=%b %0d:%0d expected 1 0:31", load, load_hours, load_minutes);
        end
        btn_mode = 1'b0;
        step();
        // Minute wrap 59 -> 0 must leave hours untouched.
        cur_hours = 4'd4; cur_minutes = 6'd59; cur_seconds = 6'd20;
        press_mode_btn();
        press_mode_btn();
        press_inc_btn();
        btn_mode = 1'b1;
        step();
        n_vec++; if (load !== 1'b1 || load_hours !== 4'd4 || load_minutes !== 6'd0 || load_seconds !== 6'd0) begin
            n_err++; $display("FAIL minute_wrap: got load=%b %0d:%0d:%0d expected 1 4:0:0", load, load_hours, load_minutes, load_seconds);
        end
        btn_mode = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp_min;
        cur_hours = 4'd7; cur_minutes = 6'd20; cur_seconds = 6'd0;
        press_mode_btn();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        n_vec++; if (mode !== 2'd2) begin n_err++; $display("FAIL simul_mode: got %0d expected 2", mode); end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
`ifndef CLOCK_SET_AUTO_REPEAT_EN
        btn_inc = 1'b1;
        repeat (50) step();
        btn_inc = 1'b0;
        step();
        exp_min = 6'd21;
`else
        exp_min = 6'd20;
`endif
        btn_mode = 1'b1;
        step();
        n_vec++; if (load !== 1'b1 || load_hours !== 4'd7 || load_minutes !== exp_min) begin
            n_err++; $display("FAIL simul_load: got load=%b %0d:%0d expected 1 7:%0d", load, load_hours, load_minutes, exp_min);
        end
        btn_mode = 1'b0;
        step();
    endtask

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        cur_hours = 4'd2; cur_minutes = 6'd0; cur_seconds = 6'd33;
        press_mode_btn();
        press_mode_btn();
        btn_inc = 1'b1;
        repeat (13) step();
        btn_inc = 1'b0;
        step();
        btn_mode = 1'b1;
        step();
        n_vec++; if (load !== 1'b1 || load_hours !== 4'd2 || load_minutes !== 6'd4) begin
            n_err++; $display("FAIL auto_repeat: got load=%b %0d:%0d expected 1 2:4", load, load_hours, load_minutes);
        end
        btn_mode = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_rst_mid_edit();
        test_set();
        test_wrap();
        test_simultaneous();
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
